mem_subword_unit: RTL and testbench

MEM_SUBWORD_UNIT -- requirements
Module: mem_subword_unit

---
 rtl/mem_subword_pkg.sv | 52 +++++
 rtl/subword_lane_ext.sv | 42 ++++
 rtl/mem_subword_unit.sv | 136 +++++++++++++
 tb/tb_mem_subword_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_subword_pkg.sv
// mem_subword_pkg: shared encodings and lane helpers for the sub-word memory
// access unit (access sizes, FSM states, byte-enable and store-data shaping).
package mem_subword_pkg;

   // Access size encodings carried on size_i.
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Transaction FSM states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } state_e;

   // A request is legal when its size is defined and the address is naturally aligned.
   function automatic logic req_legal(input logic [1:0] size, input logic [1:0] offset);
      logic ok;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~offset[0];
         SZ_WORD: ok = (offset == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte-enable mask for an access; loads and stores share the same mask.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
      logic [3:0] mask;
      case (size)
         SZ_BYTE: mask = 4'b0001 << offset;
         SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
         default: mask = 4'b1111;
      endcase
      return mask;
   endfunction

   // Replicates the significant low bits of store data across every lane so
   // the byte enables alone pick the destination bytes.
   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] data;
      case (size)
         SZ_BYTE: data = {4{wdata[7:0]}};
         SZ_HALF: data = {2{wdata[15:0]}};
         default: data = wdata;
      endcase
      return data;
   endfunction

endpackage

// File: rtl/subword_lane_ext.sv
// subword_lane_ext: picks the addressed byte/halfword lane out of a memory
// word and zero- or sign-extends it to 32 bits. Words pass through untouched.
module subword_lane_ext
   import mem_subword_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        zero_ext,
   output logic [31:0] result
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic        fill;

   // Lane selection, sign fill and final width extension.
   always_comb begin
      lane_byte = word[7:0];
      lane_half = offset[1] ? word[31:16] : word[15:0];
      fill      = 1'b0;
      result    = word;
      case (offset)
         2'b00:   lane_byte = word[7:0];
         2'b01:   lane_byte = word[15:8];
         2'b10:   lane_byte = word[23:16];
         default: lane_byte = word[31:24];
      endcase
      case (size)
         SZ_BYTE: begin
            fill   = ~zero_ext & lane_byte[7];
            result = {{24{fill}}, lane_byte};
         end
         SZ_HALF: begin
            fill   = ~zero_ext & lane_half[15];
            result = {{16{fill}}, lane_half};
         end
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_subword_unit.sv
// mem_subword_unit: turns CPU byte/halfword/word loads and stores into
// word-aligned memory transactions with byte enables, and extends load data.
// Optional build macro MEM_SUBWORD_TIMEOUT_EN: abort an ACCESS after
// ACK_TIMEOUT cycles without mem_ack_i and report an error.
//
// Memory handshake: mem_req_o rises when ACCESS is entered and stays high
// with stable mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o until the cycle in
// which mem_ack_i=1 is seen; that cycle transfers the data and completes the
// request. mem_ack_i is ignored outside ACCESS.
module mem_subword_unit
   import mem_subword_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        done_o,
   output logic        err_o,
   output logic        busy_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic [1:0]  state_o
);

   state_e      state;
   logic [1:0]  offset_q;
   logic [1:0]  size_q;
   logic        zero_ext_q;
   logic [31:0] load_data;

`ifdef MEM_SUBWORD_TIMEOUT_EN
   localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   logic [CW-1:0] wait_cnt;
`else
   logic unused_cfg;
   assign unused_cfg = (ACK_TIMEOUT > 0);
`endif

   assign busy_o  = (state != ST_IDLE);
   assign state_o = state;

   subword_lane_ext u_lane_ext (
      .word     (mem_rdata_i),
      .offset   (offset_q),
      .size     (size_q),
      .zero_ext (zero_ext_q),
      .result   (load_data)
   );

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= ST_IDLE;
         offset_q    <= 2'b00;
         size_q      <= SZ_BYTE;
         zero_ext_q  <= 1'b0;
         rdata_o     <= '0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= 4'b0000;
         mem_wdata_o <= '0;
`ifdef MEM_SUBWORD_TIMEOUT_EN
         wait_cnt    <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               done_o <= 1'b0;
               err_o  <= 1'b0;
               if (req_i) begin
                  if (req_legal(size_i, addr_i[1:0])) begin
                     state       <= ST_ACCESS;
                     offset_q    <= addr_i[1:0];
                     size_q      <= size_i;
                     zero_ext_q  <= unsigned_i;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= we_i;
                     mem_addr_o  <= {addr_i[31:2], 2'b00};
                     mem_be_o    <= lane_mask(size_i, addr_i[1:0]);
                     mem_wdata_o <= store_data(size_i, wdata_i);
`ifdef MEM_SUBWORD_TIMEOUT_EN
                     wait_cnt    <= '0;
`endif
                  end else begin
                     // Bad size or alignment: report immediately, never touch memory.
                     state  <= ST_DONE;
                     done_o <= 1'b1;
                     err_o  <= 1'b1;
                  end
               end
            end
            ST_ACCESS: begin
               if (mem_ack_i) begin
                  state     <= ST_DONE;
                  mem_req_o <= 1'b0;
                  done_o    <= 1'b1;
                  if (!mem_we_o) begin
                     rdata_o <= load_data;
                  end
               end
`ifdef MEM_SUBWORD_TIMEOUT_EN
               else if (wait_cnt == CW'(ACK_TIMEOUT - 1)) begin
                  state     <= ST_DONE;
                  mem_req_o <= 1'b0;
                  done_o    <= 1'b1;
                  err_o     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            default: begin
               state  <= ST_IDLE;
               done_o <= 1'b0;
               err_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_subword_unit.sv
// tb_mem_subword_unit: table-driven and directed checks for mem_subword_unit,
// with a done/err/rdata scoreboard fed at request time.
module tb_mem_subword_unit;

`ifdef MEM_SUBWORD_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 16;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [1:0]  size_i = 2'b00;
   logic        unsigned_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [31:0] rdata_o;
   logic        done_o;
   logic        err_o;
   logic        busy_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_ack_i = 1'b0;
   logic [1:0]  state_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] model_rdata = '0;
   logic [32:0] exp_q[$];

   mem_subword_unit #(.ACK_TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
      .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .mem_req_o(mem_req_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .state_o(state_o)
   );

   // Clock.
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mdata;
      int          delay;
      logic        err;
      logic [3:0]  be;
      logic [31:0] mwdata;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] mdata, input int delay, input logic err,
                               input logic [3:0] be, input logic [31:0] mwdata,
                               input logic [31:0] rdata);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.mdata = mdata; v.delay = delay; v.err = err; v.be = be; v.mwdata = mwdata;
      v.rdata = rdata;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every done_o pulse must match the oldest pending expectation.
   always @(negedge clk_i) begin
      if (rst_i && done_o) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done_o=1, expected no completion at %0t", $time);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("sb_err", {31'd0, err_o}, {31'd0, e[32]});
            check("sb_rdata", rdata_o, e[31:0]);
         end
      end
   end

   // Drives one request (called just after a rising edge) and plays the memory side.
   task automatic run_vec(input vec_t v);
      req_i = 1'b1; we_i = v.we; size_i = v.size; unsigned_i = v.uns;
      addr_i = v.addr; wdata_i = v.wdata;
      if (!v.err && !v.we) model_rdata = v.rdata;
      exp_q.push_back({v.err, model_rdata});
      @(posedge clk_i); #1;
      req_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; size_i = 2'($urandom_range(0, 3));
      if (v.err) begin
         check("err_done", {31'd0, done_o}, 32'd1);
         check("err_no_mem_req", {31'd0, mem_req_o}, 32'd0);
      end else begin
         check("mem_req", {31'd0, mem_req_o}, 32'd1);
         check("mem_we", {31'd0, mem_we_o}, {31'd0, v.we});
         check("mem_addr", mem_addr_o, v.addr & 32'hFFFF_FFFC);
         check("mem_be", {28'd0, mem_be_o}, {28'd0, v.be});
         if (v.we) check("mem_wdata", mem_wdata_o, v.mwdata);
         for (int i = 0; i < v.delay; i++) begin
            @(posedge clk_i); #1;
            check("mem_req_hold", {31'd0, mem_req_o}, 32'd1);
            check("no_early_done", {31'd0, done_o}, 32'd0);
         end
         mem_ack_i = 1'b1; mem_rdata_i = v.mdata;
         @(posedge clk_i); #1;
         mem_ack_i = 1'b0; mem_rdata_i = $urandom;
         check("done_latency", {31'd0, done_o}, 32'd1);
         check("mem_req_drop", {31'd0, mem_req_o}, 32'd0);
      end
      @(posedge clk_i); #1;
      check("back_idle", {31'd0, busy_o}, 32'd0);
      check("done_one_cycle", {31'd0, done_o}, 32'd0);
   endtask

   // Stimulus.
   initial begin
      //            we    size   uns   addr          wdata         mdata         dly err   be       mwdata        rdata
      vecs[0]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_FF7F, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80);
      vecs[1]  = mk(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        32'h8001_1234, 1, 1'b0, 4'b1100, 32'h0,        32'h0000_8001);
      vecs[2]  = mk(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'hDEAD_BEEF, 32'h0,        0, 1'b0, 4'b0010, 32'hEFEF_EFEF, 32'h0);
      vecs[3]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
      vecs[4]  = mk(1'b0, 2'b00, 1'b1, 32'h0000_5000, 32'h0,        32'h1234_56F0, 0, 1'b0, 4'b0001, 32'h0,        32'h0000_00F0);
      vecs[5]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_6000, 32'h0,        32'h0000_8765, 0, 1'b0, 4'b0011, 32'h0,        32'hFFFF_8765);
      vecs[6]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_7004, 32'h0,        32'hCAFE_BABE, 2, 1'b0, 4'b1111, 32'h0,        32'hCAFE_BABE);
      vecs[7]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_8002, 32'h1111_ABCD, 32'h0,        1, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
      vecs[8]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_9000, 32'h0123_4567, 32'h0,        0, 1'b0, 4'b1111, 32'h0123_4567, 32'h0);
      vecs[9]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_A001, 32'h5555_5555, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
      vecs[10] = mk(1'b0, 2'b11, 1'b0, 32'h0000_B000, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
      vecs[11] = mk(1'b0, 2'b00, 1'b0, 32'h0000_C002, 32'h0,        32'h007F_0000, 3, 1'b0, 4'b0100, 32'h0,        32'h0000_007F);
      vecs[12] = mk(1'b1, 2'b00, 1'b0, 32'h0000_D003, 32'h0000_00A5, 32'h0,        0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0);

      // Reset state.
      #12;
      check("rst_rdata", rdata_o, 32'h0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_err", {31'd0, err_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
      check("rst_mem_addr", mem_addr_o, 32'h0);
      check("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
      check("rst_mem_wdata", mem_wdata_o, 32'h0);
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      // Table vectors.
      for (int i = 0; i < 13; i++) run_vec(vecs[i]);

      // Random loads and stores against a shift-based lane model.
      for (int i = 0; i < 20; i++) begin
         vec_t v;
         logic [31:0] sh;
         int off;
         v.we = 1'($urandom_range(0, 1));
         v.size = 2'($urandom_range(0, 2));
         v.uns = 1'($urandom_range(0, 1));
         v.addr = $urandom;
         v.wdata = $urandom;
         v.mdata = $urandom;
         v.delay = $urandom_range(0, 3);
         off = int'(v.addr[1:0]);
         sh = v.mdata >> (8 * off);
         v.err = (v.size == 2'b01 && v.addr[0]) || (v.size == 2'b10 && v.addr[1:0] != 2'b00);
         if (v.size == 2'b00) begin
            v.be = 4'(1 << off);
            v.mwdata = v.wdata[7:0] * 32'h0101_0101;
            v.rdata = (!v.uns && sh[7]) ? (32'hFFFF_FF00 | (sh & 32'hFF)) : (sh & 32'hFF);
         end else if (v.size == 2'b01) begin
            v.be = 4'(3 << off);
            v.mwdata = v.wdata[15:0] * 32'h0001_0001;
            v.rdata = (!v.uns && sh[15]) ? (32'hFFFF_0000 | (sh & 32'hFFFF)) : (sh & 32'hFFFF);
         end else begin
            v.be = 4'hF;
            v.mwdata = v.wdata;
            v.rdata = v.mdata;
         end
         run_vec(v);
      end

      // Ack in IDLE is ignored.
      mem_ack_i = 1'b1; mem_rdata_i = 32'h1357_9BDF;
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      check("idle_ack_busy", {31'd0, busy_o}, 32'd0);
      check("idle_ack_rdata", rdata_o, model_rdata);

      // Request while busy is dropped, not queued.
      req_i = 1'b1; we_i = 1'b0; size_i = 2'b01; unsigned_i = 1'b1; addr_i = 32'h10;
      model_rdata = 32'h0000_BEEF;
      exp_q.push_back({1'b0, model_rdata});
      @(posedge clk_i); #1;
      addr_i = 32'h21;
      repeat (2) begin
         @(posedge clk_i); #1;
         check("busy_during_access", {31'd0, busy_o}, 32'd1);
      end
      req_i = 1'b0;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_BEEF;
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      check("busy_req_done", {31'd0, done_o}, 32'd1);
      repeat (2) begin
         @(posedge clk_i); #1;
         check("busy_req_not_queued", {31'd0, busy_o}, 32'd0);
      end

      // Reset in mid-ACCESS abandons the transaction.
      req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; addr_i = 32'h0000_0100; wdata_i = 32'h600D_F00D;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #2;
      check("pre_rst_mem_req", {31'd0, mem_req_o}, 32'd1);
      rst_i = 1'b0;
      #1;
      model_rdata = 32'h0;
      check("mid_rst_state", {30'd0, state_o}, 32'd0);
      check("mid_rst_rdata", rdata_o, 32'h0);
      check("mid_rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      check("mid_rst_mem_be", {28'd0, mem_be_o}, 32'd0);
      check("mid_rst_mem_addr", mem_addr_o, 32'h0);
      check("mid_rst_mem_wdata", mem_wdata_o, 32'h0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      mem_ack_i = 1'b1;
      repeat (3) begin
         @(posedge clk_i); #1;
         mem_ack_i = 1'b0;
         check("post_rst_no_done", {31'd0, done_o}, 32'd0);
      end
      run_vec(vecs[0]);

`ifdef MEM_SUBWORD_TIMEOUT_EN
      // Ack never arrives: request held for exactly ACK_TIMEOUT cycles.
      begin
         int cnt;
         cnt = 0;
         req_i = 1'b1; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0; addr_i = 32'h20;
         exp_q.push_back({1'b1, model_rdata});
         @(posedge clk_i); #1;
         req_i = 1'b0;
         for (int i = 0; i < 20 && mem_req_o; i++) begin
            cnt++;
            @(posedge clk_i); #1;
         end
         check("timeout_req_cycles", cnt, TO);
         check("timeout_done", {31'd0, done_o}, 32'd1);
         check("timeout_err", {31'd0, err_o}, 32'd1);
         check("timeout_rdata", rdata_o, model_rdata);
         @(posedge clk_i); #1;
      end
`endif

      repeat (2) @(posedge clk_i);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
